mul_sched: RTL and testbench

- Two-requester scheduler and sequencer for the shared fixed-latency 32-bit multiplier datapath.
- Arbitrates between requesters round-robin and registers the winning operand pair onto the multiplier inputs.
- Tracks in-flight operations in a valid/tag shift pipe and captures results into a response buffer with valid/ready backpressure.
- Sits between the execute-stage issue logic (req0) and the coprocessor/accelerator port (req1) on one side and the multiplier on the other.

---
 rtl/mul_sched_pkg.sv | 32 +++
 rtl/mul_sched_fifo.sv | 80 ++++++++
 rtl/mul_sched.sv | 205 ++++++++++++++++++++
 tb/tb_mul_sched.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_sched_pkg
// Description : Shared constants and entry types for the multiplier
//               scheduler (pipe tracking entries and response buffer entries).
// Revision    : 1.0 - initial release
// ============================================================================
package mul_sched_pkg;

    localparam int unsigned DATA_W    = 32;
    // Tag width carried by the entry types; the top checks its TAG_W against it.
    localparam int unsigned PKG_TAG_W = 5;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    // One in-flight multiply tracked alongside the multiplier latency.
    typedef struct packed {
        logic                 valid;
        logic                 id;
        logic [PKG_TAG_W-1:0] tag;
    } pipe_entry_t;

    // One completed multiply waiting for the consumer.
    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [PKG_TAG_W-1:0] tag;
        logic                 id;
    } buf_entry_t;

endpackage
`default_nettype wire

// File: rtl/mul_sched_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mul_sched_fifo
// Description : Show-ahead synchronous response FIFO with flush. Head entry is
//               presented combinationally from storage; storage is cleared by
//               reset so the head reads zero until the first push.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_sched_fifo
    import mul_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       flush,
    input  logic       push,
    input  buf_entry_t push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output buf_entry_t head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    buf_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A flush discards the buffer, so neither a push nor a pop takes effect.
    assign w_push = push & ~full & ~flush;
    assign w_pop  = pop & ~empty & ~flush;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

    // Storage write; reset zeroes it so the idle head reads as all-zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; flush empties without touching storage.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : mul_sched
// Description : Two-requester round-robin scheduler for a shared fixed-latency
//               32-bit multiplier. Registers the winning operands, tracks
//               in-flight ops in a valid/tag pipe and buffers results for a
//               valid/ready consumer. Credits bound outstanding ops to
//               BUF_DEPTH so the buffer never overflows.
//               Optional: define MUL_SCHED_PERF_EN for issue/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned BUF_DEPTH = 4,
    parameter int unsigned TAG_W     = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic [DATA_W-1:0] mul_multiplier,
    output logic [DATA_W-1:0] mul_multiplicand,
    input  logic [DATA_W-1:0] mul_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_id,
    output logic [31:0]       perf_issue_cnt,
    output logic [31:0]       perf_stall_cnt
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    // Entry types carry a fixed tag width; refuse to build with any other.
    generate
        if (TAG_W != PKG_TAG_W) begin : g_tag_w_check
            $error("mul_sched: TAG_W must equal PKG_TAG_W");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic             r_last_grant;
    pipe_entry_t      r_pipe [LATENCY];
    pipe_entry_t      w_issue;
    buf_entry_t       w_push_data;
    buf_entry_t       w_head;
    logic             w_credit_ok;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    // A credit is only returned by a completed pop; no same-cycle bypass.
    assign w_credit_ok = (r_cnt < CNT_W'(BUF_DEPTH));

    // r_last_grant==1 means req0 last lost (or reset): req0 wins the tie.
    assign req0_ready = resetn & w_credit_ok & ~flush & (~req1_valid | r_last_grant);
    assign req1_ready = resetn & w_credit_ok & ~flush & (~req0_valid | ~r_last_grant);

    assign w_acc0   = req0_valid & req0_ready;
    assign w_acc1   = req1_valid & req1_ready;
    assign w_accept = w_acc0 | w_acc1;

    // Build the tracking entry for the op being issued this cycle.
    always_comb begin
        w_issue = '0;
        if (w_acc0) begin
            w_issue.valid = 1'b1;
            w_issue.id    = ID_REQ0;
            w_issue.tag   = req0_tag;
        end else if (w_acc1) begin
            w_issue.valid = 1'b1;
            w_issue.id    = ID_REQ1;
            w_issue.tag   = req1_tag;
        end
    end

    // Operand registers feed the multiplier and hold until the next accept.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
        end else if (w_acc0) begin
            mul_multiplier   <= req0_a;
            mul_multiplicand <= req0_b;
        end else if (w_acc1) begin
            mul_multiplier   <= req1_a;
            mul_multiplicand <= req1_b;
        end
    end

    // Round-robin state: remember who won; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_acc1;
        end
    end

    // In-flight tracking pipe, shifting every cycle in step with the multiplier.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_issue;
            for (int i = 1; i < int'(LATENCY); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // The multiplier output lines up with the last pipe stage.
    assign w_push           = r_pipe[LATENCY-1].valid;
    assign w_push_data.data = mul_result;
    assign w_push_data.tag  = r_pipe[LATENCY-1].tag;
    assign w_push_data.id   = r_pipe[LATENCY-1].id;

    assign w_pop = ~w_empty & rsp_ready;

    mul_sched_fifo #(
        .DEPTH     (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    assign rsp_valid = ~w_empty;
    assign rsp_data  = w_head.data;
    assign rsp_tag   = w_head.tag;
    assign rsp_id    = w_head.id;

    // Outstanding ops (in flight plus buffered); flush drops them all.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            r_cnt <= '0;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef MUL_SCHED_PERF_EN
    logic [31:0] r_perf_issue;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    // Any waiting requester while credits are exhausted is a stall cycle.
    assign w_stall = ~w_credit_ok & (req0_valid | req1_valid);

    // Free-running counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_perf_issue <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_accept) begin
                r_perf_issue <= r_perf_issue + 32'd1;
            end
            if (w_stall) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = r_perf_issue;
    assign perf_stall_cnt = r_perf_stall;
`else
    assign perf_issue_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

    // Full status is implied by the credit count; kept for readability.
    logic w_unused_full;
    assign w_unused_full = w_full;

endmodule
`default_nettype wire

// File: tb/tb_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_sched
// Description : Self-checking bench for mul_sched: vector table, directed
//               multi-cycle sequences and randomized traffic against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mul_sched;

    localparam int LATENCY   = 2;
    localparam int BUF_DEPTH = 4;
    localparam int TAG_W     = 5;

    logic             clk = 1'b0;
    logic             resetn, flush;
    logic             req0_valid, req1_valid, rsp_ready;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic [TAG_W-1:0] req0_tag, req1_tag;
    logic [31:0]      mul_multiplier, mul_multiplicand, mul_result, mul_q;
    logic             rsp_valid, rsp_id;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      perf_issue_cnt, perf_stall_cnt;

    mul_sched #(.LATENCY(LATENCY), .BUF_DEPTH(BUF_DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
        .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_id(rsp_id),
        .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    // Two-cycle multiplier: one register stage after the operand registers.
    always @(posedge clk) mul_q <= mul_multiplier * mul_multiplicand;
    assign mul_result = mul_q;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        bit               id;
        int               avail;
    } rsp_t;

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        bit               id;
        logic [31:0]      exp;
    } vec_t;

    // Reference model state: every outstanding op with the cycle it becomes visible.
    rsp_t        m_q[$];
    int          m_cyc;
    bit          m_last;
    logic [31:0] m_a, m_b, m_issue, m_stall;
    bit          d_acc0, d_acc1;
    int          n_checks, n_errors;
    vec_t        vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: check outputs against the model, then advance both.
    task automatic step();
        bit   credit, e_r0, e_r1, e_rv, a0, a1, pop, stall;
        rsp_t e;
        #1;
        credit = (m_q.size() < BUF_DEPTH);
        e_r0   = resetn && credit && !flush && (!req1_valid || m_last);
        e_r1   = resetn && credit && !flush && (!req0_valid || !m_last);
        e_rv   = (m_q.size() > 0) && (m_q[0].avail <= m_cyc);
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("rsp_valid", rsp_valid, e_rv);
        if (e_rv) begin
            chk("rsp_data", rsp_data, m_q[0].data);
            chk("rsp_tag", rsp_tag, m_q[0].tag);
            chk("rsp_id", rsp_id, m_q[0].id);
        end
        chk("mul_multiplier", mul_multiplier, m_a);
        chk("mul_multiplicand", mul_multiplicand, m_b);
`ifdef MUL_SCHED_PERF_EN
        chk("perf_issue_cnt", perf_issue_cnt, m_issue);
        chk("perf_stall_cnt", perf_stall_cnt, m_stall);
`else
        chk("perf_issue_cnt", perf_issue_cnt, 32'd0);
        chk("perf_stall_cnt", perf_stall_cnt, 32'd0);
`endif
        d_acc0 = req0_valid && req0_ready;
        d_acc1 = req1_valid && req1_ready;
        a0     = req0_valid && e_r0;
        a1     = req1_valid && e_r1;
        pop    = e_rv && rsp_ready;
        stall  = resetn && !credit && (req0_valid || req1_valid);
        e.data = a0 ? req0_a * req0_b : req1_a * req1_b;
        e.tag  = a0 ? req0_tag : req1_tag;
        e.id   = a1;
        @(posedge clk);
        m_cyc++;
        if (!resetn) begin
            m_q.delete();
            m_last = 1'b1; m_a = '0; m_b = '0; m_issue = '0; m_stall = '0;
        end else begin
            if (pop) m_q.delete(0);
            if (flush) m_q.delete();
            if (a0 || a1) begin
                e.avail = m_cyc + LATENCY;
                m_q.push_back(e);
                m_last = a1;
                m_a = a0 ? req0_a : req1_a;
                m_b = a0 ? req0_b : req1_b;
                m_issue++;
            end
            if (stall) m_stall++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
        step();
        resetn = 1'b1;
    endtask

    // Wait (bounded) for a response and compare it with constant expectations.
    task automatic await_rsp(input string name, input logic [31:0] exp_d,
                             input logic [TAG_W-1:0] exp_t, input bit exp_id);
        int t;
        t = 0;
        while (!rsp_valid && t < 10) begin
            step();
            t++;
        end
        chk({name, "_latency"}, t, LATENCY);
        chk({name, "_data"}, rsp_data, exp_d);
        chk({name, "_tag"}, rsp_tag, exp_t);
        chk({name, "_id"}, rsp_id, exp_id);
    endtask

    initial begin
        int acc;
        vecs[0] = '{32'd3,        32'd5,        5'd7,  1'b0, 32'd15};
        vecs[1] = '{32'hFFFFFFFE, 32'd3,        5'd12, 1'b1, 32'hFFFFFFFA};
        vecs[2] = '{32'd4,        32'd4,        5'd1,  1'b0, 32'd16};
        vecs[3] = '{32'h80000000, 32'd2,        5'd31, 1'b1, 32'h00000000};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  1'b0, 32'h00000001};
        vecs[5] = '{32'h12345678, 32'h10,       5'd20, 1'b1, 32'h23456780};

        n_checks = 0; n_errors = 0;
        resetn = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_tag = '0;
        req1_a = '0; req1_b = '0; req1_tag = '0;
        m_cyc = 0; m_last = 1'b1; m_a = '0; m_b = '0; m_issue = '0; m_stall = '0;
        @(posedge clk);
        @(negedge clk);
        step();
        chk("reset_rsp_data", rsp_data, 32'd0);
        chk("reset_rsp_tag", rsp_tag, 0);
        resetn = 1'b1;

        // Single isolated ops from the vector table.
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].id) begin
                req1_valid = 1'b1; req1_a = vecs[i].a; req1_b = vecs[i].b; req1_tag = vecs[i].tag;
            end else begin
                req0_valid = 1'b1; req0_a = vecs[i].a; req0_b = vecs[i].b; req0_tag = vecs[i].tag;
            end
            step();
            chk("vec_accept", vecs[i].id ? d_acc1 : d_acc0, 1'b1);
            req0_valid = 1'b0; req1_valid = 1'b0;
            await_rsp("vec", vecs[i].exp, vecs[i].tag, vecs[i].id);
            step();
        end

        // Contention from reset: strict alternation starting with req0.
        do_reset();
        rsp_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_a = $urandom; req0_b = $urandom; req0_tag = TAG_W'(i);
            req1_a = $urandom; req1_b = $urandom; req1_tag = TAG_W'(i + 8);
            step();
            chk("contention_grant", {30'd0, d_acc1, d_acc0}, (i % 2 == 1) ? 32'd2 : 32'd1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) step();

        // Backpressure: four credits, then a single pop frees exactly one.
        do_reset();
        rsp_ready = 1'b0; req0_valid = 1'b1; acc = 0;
        for (int i = 0; i < 8; i++) begin
            req0_a = i + 2; req0_b = 3; req0_tag = TAG_W'(i);
            step();
            acc += int'(d_acc0);
        end
        chk("bp_accepts", acc, 4);
`ifdef MUL_SCHED_PERF_EN
        chk("bp_stall_cnt", perf_stall_cnt, 32'd4);
`endif
        rsp_ready = 1'b1;
        step();
        chk("bp_no_bypass", d_acc0, 1'b0);
        rsp_ready = 1'b0; acc = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            acc += int'(d_acc0);
        end
        chk("bp_one_more", acc, 1);
        req0_valid = 1'b0;

        // Flush with two in flight and one buffered.
        do_reset();
        rsp_ready = 1'b0; req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_a = i + 1; req0_b = 2; req0_tag = TAG_W'(i);
            step();
        end
        chk("flush_pre_valid", rsp_valid, 1'b1);
        req0_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("flush_rsp_valid", rsp_valid, 1'b0);
        end
        rsp_ready = 1'b1; req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd4; req0_tag = 5'd9;
        step();
        chk("flush_new_accept", d_acc0, 1'b1);
        req0_valid = 1'b0;
        await_rsp("flush_new", 32'd16, 5'd9, 1'b0);
        step();

        // Reset with three ops outstanding.
        rsp_ready = 1'b0; req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_a = 32'h100 + i; req0_b = 32'd7; req0_tag = TAG_W'(i + 3);
            step();
        end
        resetn = 1'b0;
        step();
        #1;
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_mul_multiplier", mul_multiplier, 32'd0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_perf_issue", perf_issue_cnt, 32'd0);
        resetn = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        req1_a = 32'd9; req1_b = 32'd9; req1_tag = 5'd2;
        step();
        chk("rst_first_tie", {30'd0, d_acc1, d_acc0}, 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) step();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 5);
            req0_a = $urandom; req0_b = $urandom; req0_tag = TAG_W'($urandom);
            req1_a = $urandom; req1_b = $urandom; req1_tag = TAG_W'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 39) == 0);
            resetn = ($urandom_range(0, 199) != 0);
            step();
        end
        resetn = 1'b1; flush = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        repeat (8) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
